// File: rtl/xgmii_rx_filter.sv
// ============================================================================
// Module      : xgmii_rx_filter
// Description : XGMII receive filter. Checks Eth/IPv4/UDP/magic headers and
//               streams matching payload into a 72-bit framed RX FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xgmii_rx_filter #(
    parameter logic [15:0] UDP_PORT      = 16'd3422,
    parameter logic [31:0] MAGIC         = 32'h5A5A_0001,
    parameter bit          CHECK_DST_MAC = 1'b1,
    parameter bit          CHECK_DST_IP  = 1'b1,
    parameter int          MAX_WORDS     = 190,
    parameter int          CNT_W         = 32
) (
    input  logic             xgmii_clk,
    input  logic             sys_rst_n,
    input  logic [7:0]       xgmii_rxc,
    input  logic [63:0]      xgmii_rxd,
    input  logic [31:0]      if_v4addr,
    input  logic [47:0]      if_macaddr,
    output logic [71:0]      din,
    input  logic             full,
    output logic             wr_en,
    output logic [CNT_W-1:0] rx_frames,
    output logic [CNT_W-1:0] match_frames,
    output logic [CNT_W-1:0] drop_frames,
    output logic             err,
    output logic [7:0]       led
);

    localparam int          W_W          = $clog2(MAX_WORDS + 8);
    localparam logic [71:0] c_eof_marker = {1'b1, 71'd0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PAY  = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [W_W-1:0]   w_q, w_d;
    logic             hdr_ok_q, hdr_ok_d;
    logic             hold_vld_q, hold_vld_d;
    logic             hold_term_q, hold_term_d;
    logic [63:0]      hold_data_q, hold_data_d;
    logic [3:0]       hold_cnt_q, hold_cnt_d;
    logic             out_vld_q, out_vld_d;
    logic [71:0]      din_q, din_d;
    logic             pending_eof_q, pending_eof_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rx_frames_q, rx_frames_d;
    logic [CNT_W-1:0] match_frames_q, match_frames_d;
    logic [CNT_W-1:0] drop_frames_q, drop_frames_d;

    logic [7:0]  w_b [8];
    logic        w_start;
    logic        w_term;
    logic [2:0]  w_term_lane;
    logic [63:0] w_partial;
    logic        w_hdr_ok;
    logic [47:0] w_mac;
    logic        w_trunc_max;
    logic        w_trunc;

    // Byte lanes, start/terminate detection and masked partial word
    always_comb begin
        w_term      = 1'b0;
        w_term_lane = 3'd0;
        w_partial   = 64'd0;
        for (int i = 0; i < 8; i++) begin
            w_b[i] = xgmii_rxd[8*i +: 8];
        end
        w_start = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hFB);
        for (int i = 7; i >= 0; i--) begin
            if (xgmii_rxc[i] && (xgmii_rxd[8*i +: 8] == 8'hFD)) begin
                w_term      = 1'b1;
                w_term_lane = 3'(i);
            end
        end
        if (xgmii_rxc == 8'hFF) begin
            w_term      = 1'b1;
            w_term_lane = 3'd0;
        end
        for (int i = 0; i < 8; i++) begin
            if (3'(i) < w_term_lane) begin
                w_partial[8*i +: 8] = xgmii_rxd[8*i +: 8];
            end
        end
    end

    // Per-word header field check, indexed by the current word number
    always_comb begin
        w_hdr_ok = 1'b1;
        w_mac    = {w_b[0], w_b[1], w_b[2], w_b[3], w_b[4], w_b[5]};
        case (w_q)
            W_W'(1): w_hdr_ok = !CHECK_DST_MAC || (w_mac == if_macaddr) ||
                                (w_mac == 48'hFFFF_FFFF_FFFF);
            W_W'(2): w_hdr_ok = ({w_b[4], w_b[5]} == 16'h0800);
            W_W'(3): w_hdr_ok = (w_b[7] == 8'h11);
            W_W'(4): w_hdr_ok = !CHECK_DST_IP ||
                                ({w_b[6], w_b[7]} == if_v4addr[31:16]);
            W_W'(5): w_hdr_ok = (!CHECK_DST_IP ||
                                 ({w_b[0], w_b[1]} == if_v4addr[15:0])) &&
                                ({w_b[4], w_b[5]} == UDP_PORT);
            W_W'(6): w_hdr_ok = ({w_b[2], w_b[3], w_b[4], w_b[5]} == MAGIC);
            default: w_hdr_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        w_d            = w_q;
        hdr_ok_d       = hdr_ok_q;
        hold_vld_d     = hold_vld_q;
        hold_term_d    = hold_term_q;
        hold_data_d    = hold_data_q;
        hold_cnt_d     = hold_cnt_q;
        out_vld_d      = out_vld_q & full;
        din_d          = din_q;
        pending_eof_d  = pending_eof_q & full;
        err_d          = 1'b0;
        rx_frames_d    = rx_frames_q;
        match_frames_d = match_frames_q;
        drop_frames_d  = drop_frames_q;
        w_trunc_max    = 1'b0;

        // Second half of a split terminate: the partial word follows the held one
        if (hold_term_q) begin
            din_d       = {1'b1, 3'b000, hold_cnt_q, hold_data_q};
            out_vld_d   = 1'b1;
            hold_term_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_start) begin
                    rx_frames_d = rx_frames_q + CNT_W'(1);
                    w_d         = W_W'(1);
                    hdr_ok_d    = 1'b1;
                    state_d     = pending_eof_q ? ST_DROP : ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_term) begin
                    state_d = ST_IDLE;
                end else begin
                    w_d      = w_q + W_W'(1);
                    hdr_ok_d = hdr_ok_q & w_hdr_ok;
                    if (w_q == W_W'(6)) begin
                        if (hdr_ok_q && w_hdr_ok) begin
                            state_d        = ST_PAY;
                            match_frames_d = match_frames_q + CNT_W'(1);
                        end else begin
                            state_d = ST_DROP;
                        end
                    end
                end
            end
            ST_PAY: begin
                if (w_term) begin
                    if (hold_vld_q) begin
                        din_d     = {(w_term_lane == 3'd0), 3'b000, 4'd8, hold_data_q};
                        out_vld_d = 1'b1;
                    end else if (w_term_lane == 3'd0) begin
                        din_d     = c_eof_marker;
                        out_vld_d = 1'b1;
                    end
                    hold_vld_d = 1'b0;
                    if (w_term_lane != 3'd0) begin
                        hold_data_d = w_partial;
                        hold_cnt_d  = {1'b0, w_term_lane};
                        hold_term_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (w_q == W_W'(MAX_WORDS)) begin
                    w_trunc_max = 1'b1;
                end else begin
                    if (hold_vld_q) begin
                        din_d     = {1'b0, 3'b000, 4'd8, hold_data_q};
                        out_vld_d = 1'b1;
                    end
                    hold_data_d = xgmii_rxd;
                    hold_vld_d  = 1'b1;
                    w_d         = w_q + W_W'(1);
                end
            end
            default: begin
                if (w_term) begin
                    state_d = ST_IDLE;
                end
            end
        endcase

        // A data write blocked by full, or an over-long frame, drops the frame
        // and replaces any pending output with a zero-length eof marker.
        w_trunc = w_trunc_max | (out_vld_q & full & ~pending_eof_q);
        if (w_trunc) begin
            din_d         = c_eof_marker;
            out_vld_d     = 1'b1;
            pending_eof_d = 1'b1;
            hold_vld_d    = 1'b0;
            hold_term_d   = 1'b0;
            state_d       = ST_DROP;
            err_d         = 1'b1;
            drop_frames_d = drop_frames_q + CNT_W'(1);
        end
    end

    always_ff @(posedge xgmii_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q        <= ST_IDLE;
            w_q            <= '0;
            hdr_ok_q       <= 1'b0;
            hold_vld_q     <= 1'b0;
            hold_term_q    <= 1'b0;
            hold_data_q    <= 64'd0;
            hold_cnt_q     <= 4'd0;
            out_vld_q      <= 1'b0;
            din_q          <= 72'd0;
            pending_eof_q  <= 1'b0;
            err_q          <= 1'b0;
            rx_frames_q    <= '0;
            match_frames_q <= '0;
            drop_frames_q  <= '0;
        end else begin
            state_q        <= state_d;
            w_q            <= w_d;
            hdr_ok_q       <= hdr_ok_d;
            hold_vld_q     <= hold_vld_d;
            hold_term_q    <= hold_term_d;
            hold_data_q    <= hold_data_d;
            hold_cnt_q     <= hold_cnt_d;
            out_vld_q      <= out_vld_d;
            din_q          <= din_d;
            pending_eof_q  <= pending_eof_d;
            err_q          <= err_d;
            rx_frames_q    <= rx_frames_d;
            match_frames_q <= match_frames_d;
            drop_frames_q  <= drop_frames_d;
        end
    end

    assign din          = din_q;
    assign wr_en        = out_vld_q & ~full;
    assign err          = err_q;
    assign rx_frames    = rx_frames_q;
    assign match_frames = match_frames_q;
    assign drop_frames  = drop_frames_q;
    assign led          = match_frames_q[7:0];

endmodule

`default_nettype wire
